// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bus of the three-port DPRAM arbiter: request/command in, grant and read return out.
interface dpram_port_arbiter_if;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              req0,    req1,    req2;
    logic              we0,     we1,     we2;
    logic [ADDR_W-1:0] addr0,   addr1,   addr2;
    logic [DATA_W-1:0] wdata0,  wdata1,  wdata2;
    logic              ack0,    ack1,    ack2;
    logic              rvalid0, rvalid1, rvalid2;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, req1, req2,
        output we0, we1, we2,
        output addr0, addr1, addr2,
        output wdata0, wdata1, wdata2,
        input  ack0, ack1, ack2,
        input  rvalid0, rvalid1, rvalid2,
        input  rdata
    );

    modport slave (
        input  req0, req1, req2,
        input  we0, we1, we2,
        input  addr0, addr1, addr2,
        input  wdata0, wdata1, wdata2,
        output ack0, ack1, ack2,
        output rvalid0, rvalid1, rvalid2,
        output rdata
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Three-requester arbiter in front of one port of a 256x32 RAM with 2-cycle read latency.
// Grants at most one access per cycle, tracks reads through a valid/ID pipeline and
// returns read data on a shared registered rdata with a per-requester rvalid strobe.
module dpram_port_arbiter #(
    parameter  int unsigned RR     = 1,
    localparam int unsigned ADDR_W = 8,
    localparam int unsigned DATA_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    dpram_port_arbiter_if.slave  bus,
    output logic                 ram_wren,
    output logic [ADDR_W-1:0]    ram_address,
    output logic [DATA_W-1:0]    ram_data,
    input  logic [DATA_W-1:0]    ram_q
);
    localparam int unsigned N_REQ  = 3;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned PIPE_D = 3;

    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  we;
    logic [ADDR_W-1:0] addr  [N_REQ];
    logic [DATA_W-1:0] wdata [N_REQ];

    assign req      = {bus.req2, bus.req1, bus.req0};
    assign we       = {bus.we2, bus.we1, bus.we0};
    assign addr[0]  = bus.addr0;
    assign addr[1]  = bus.addr1;
    assign addr[2]  = bus.addr2;
    assign wdata[0] = bus.wdata0;
    assign wdata[1] = bus.wdata1;
    assign wdata[2] = bus.wdata2;

    logic [N_REQ-1:0]             ack_q,         ack_d;
    logic [N_REQ-1:0]             rvalid_q,      rvalid_d;
    logic [DATA_W-1:0]            rdata_q,       rdata_d;
    logic                         ram_wren_q,    ram_wren_d;
    logic [ADDR_W-1:0]            ram_address_q, ram_address_d;
    logic [DATA_W-1:0]            ram_data_q,    ram_data_d;
    logic [ID_W-1:0]              last_q,        last_d;
    logic [PIPE_D-1:0]            pipe_vld_q,    pipe_vld_d;
    logic [PIPE_D-1:0][ID_W-1:0]  pipe_id_q,     pipe_id_d;

    logic [N_REQ-1:0]  elig_c;
    logic              grant_c;
    logic [ID_W-1:0]   win_c;
    logic [ID_W-1:0]   cand_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    // Pick the winner among requesters that are asking and not being acked this cycle.
    always_comb begin
        elig_c  = req & ~ack_q;
        grant_c = 1'b0;
        win_c   = '0;
        cand_c  = '0;
        if (RR != 0) begin
            // Search starts one past the last winner and wraps 2 -> 0.
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand_c = ID_W'((32'(last_q) + k) % N_REQ);
                if (!grant_c && elig_c[cand_c]) begin
                    grant_c = 1'b1;
                    win_c   = cand_c;
                end
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand_c = ID_W'(k);
                if (!grant_c && elig_c[cand_c]) begin
                    grant_c = 1'b1;
                    win_c   = cand_c;
                end
            end
        end
    end

    // Route the winning requester's command fields to the RAM side.
    always_comb begin
        sel_we_c    = we[2];
        sel_addr_c  = addr[2];
        sel_wdata_c = wdata[2];
        case (win_c)
            2'd0: begin
                sel_we_c    = we[0];
                sel_addr_c  = addr[0];
                sel_wdata_c = wdata[0];
            end
            2'd1: begin
                sel_we_c    = we[1];
                sel_addr_c  = addr[1];
                sel_wdata_c = wdata[1];
            end
            default: ;
        endcase
    end

    // Next-state: register the grant, advance the read pipeline, return read data.
    always_comb begin
        ack_d         = '0;
        ram_wren_d    = 1'b0;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        last_d        = last_q;
        pipe_vld_d    = {pipe_vld_q[PIPE_D-2:0], 1'b0};
        pipe_id_d     = {pipe_id_q[PIPE_D-2:0], ID_W'(0)};
        rvalid_d      = '0;
        rdata_d       = rdata_q;

        if (grant_c) begin
            ack_d         = N_REQ'(32'd1 << win_c);
            ram_wren_d    = sel_we_c;
            ram_address_d = sel_addr_c;
            ram_data_d    = sel_wdata_c;
            last_d        = win_c;
            // Writes occupy the slot as a bubble so returns stay aligned.
            pipe_vld_d[0] = ~sel_we_c;
            pipe_id_d[0]  = win_c;
        end

        // Last stage lines up with the RAM's registered output.
        if (pipe_vld_q[PIPE_D-1]) begin
            rvalid_d = N_REQ'(32'd1 << pipe_id_q[PIPE_D-1]);
            rdata_d  = ram_q;
        end
    end

    // State register; reset drops in-flight reads and points round-robin at requester 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_q         <= '0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
            ram_wren_q    <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            last_q        <= ID_W'(2);
            pipe_vld_q    <= '0;
            pipe_id_q     <= '0;
        end else begin
            ack_q         <= ack_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            ram_wren_q    <= ram_wren_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            last_q        <= last_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_id_q     <= pipe_id_d;
        end
    end

    assign bus.ack0    = ack_q[0];
    assign bus.ack1    = ack_q[1];
    assign bus.ack2    = ack_q[2];
    assign bus.rvalid0 = rvalid_q[0];
    assign bus.rvalid1 = rvalid_q[1];
    assign bus.rvalid2 = rvalid_q[2];
    assign bus.rdata   = rdata_q;
    assign ram_wren    = ram_wren_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: a round-robin and a fixed-priority instance side by side,
// each with its own RAM stand-in, driven by directed scenarios then random traffic.
module tb_dpram_port_arbiter;
    localparam int N_INST = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dpram_port_arbiter_if bus_rr ();
    dpram_port_arbiter_if bus_fp ();

    logic        ram_wren    [N_INST];
    logic [7:0]  ram_address [N_INST];
    logic [31:0] ram_data    [N_INST];
    logic [31:0] ram_q       [N_INST];

    dpram_port_arbiter #(.RR(1)) dut_rr (
        .clock(clock), .reset(reset), .bus(bus_rr),
        .ram_wren(ram_wren[0]), .ram_address(ram_address[0]),
        .ram_data(ram_data[0]), .ram_q(ram_q[0])
    );

    dpram_port_arbiter #(.RR(0)) dut_fp (
        .clock(clock), .reset(reset), .bus(bus_fp),
        .ram_wren(ram_wren[1]), .ram_address(ram_address[1]),
        .ram_data(ram_data[1]), .ram_q(ram_q[1])
    );

    // Requester-side stimulus, per instance and per requester.
    logic [2:0]  req_v   [N_INST];
    logic [2:0]  we_v    [N_INST];
    logic [7:0]  addr_v  [N_INST][3];
    logic [31:0] wdata_v [N_INST][3];

    assign bus_rr.req0 = req_v[0][0];  assign bus_rr.req1 = req_v[0][1];  assign bus_rr.req2 = req_v[0][2];
    assign bus_rr.we0  = we_v[0][0];   assign bus_rr.we1  = we_v[0][1];   assign bus_rr.we2  = we_v[0][2];
    assign bus_rr.addr0 = addr_v[0][0]; assign bus_rr.addr1 = addr_v[0][1]; assign bus_rr.addr2 = addr_v[0][2];
    assign bus_rr.wdata0 = wdata_v[0][0]; assign bus_rr.wdata1 = wdata_v[0][1]; assign bus_rr.wdata2 = wdata_v[0][2];
    assign bus_fp.req0 = req_v[1][0];  assign bus_fp.req1 = req_v[1][1];  assign bus_fp.req2 = req_v[1][2];
    assign bus_fp.we0  = we_v[1][0];   assign bus_fp.we1  = we_v[1][1];   assign bus_fp.we2  = we_v[1][2];
    assign bus_fp.addr0 = addr_v[1][0]; assign bus_fp.addr1 = addr_v[1][1]; assign bus_fp.addr2 = addr_v[1][2];
    assign bus_fp.wdata0 = wdata_v[1][0]; assign bus_fp.wdata1 = wdata_v[1][1]; assign bus_fp.wdata2 = wdata_v[1][2];

    logic [2:0]  ack_o    [N_INST];
    logic [2:0]  rvalid_o [N_INST];
    logic [31:0] rdata_o  [N_INST];

    assign ack_o[0]    = {bus_rr.ack2, bus_rr.ack1, bus_rr.ack0};
    assign ack_o[1]    = {bus_fp.ack2, bus_fp.ack1, bus_fp.ack0};
    assign rvalid_o[0] = {bus_rr.rvalid2, bus_rr.rvalid1, bus_rr.rvalid0};
    assign rvalid_o[1] = {bus_fp.rvalid2, bus_fp.rvalid1, bus_fp.rvalid0};
    assign rdata_o[0]  = bus_rr.rdata;
    assign rdata_o[1]  = bus_fp.rdata;

    // RAM stand-in: write on the edge, read through two register stages.
    logic [31:0] mem      [N_INST][256];
    logic [31:0] rd_stage [N_INST];
    always @(posedge clock) begin
        for (int i = 0; i < N_INST; i++) begin
            rd_stage[i] <= mem[i][ram_address[i]];
            ram_q[i]    <= rd_stage[i];
            if (ram_wren[i]) mem[i][ram_address[i]] <= ram_data[i];
        end
    end

    // Reference model state.
    int unsigned cyc = 0;
    int          m_last  [N_INST];
    logic [2:0]  m_ack   [N_INST];
    logic        m_wren  [N_INST];
    logic [7:0]  m_addr  [N_INST];
    logic [31:0] m_data  [N_INST];
    logic [31:0] m_rdata [N_INST];
    logic [31:0] shadow  [N_INST][256];

    typedef struct {
        int unsigned due;
        int          inst;
        int          id;
        logic [31:0] data;
    } rd_exp_t;
    rd_exp_t sb [$];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    function automatic bit is_set(input logic [2:0] v, input int c);
        return ((32'(v) >> c) & 32'd1) != 32'd0;
    endfunction

    task automatic check(input int inst, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s cycle %0d: got 0x%08h expected 0x%08h",
                      (inst == 0) ? "rr" : "fp", what, cyc, act, exp);
    endtask

    // Model: winner per edge from the arbitration rules; reads book an expected return 3 cycles after the ack.
    always @(posedge clock) begin
        int         win;
        int         c;
        logic [2:0] elig;
        logic [1:0] w2;
        cyc = cyc + 1;
        for (int i = 0; i < N_INST; i++) begin
            if (reset) begin
                m_last[i]  = 2;
                m_ack[i]   = 3'b000;
                m_wren[i]  = 1'b0;
                m_addr[i]  = 8'h00;
                m_data[i]  = 32'h0;
                m_rdata[i] = 32'h0;
                for (int k = sb.size() - 1; k >= 0; k--)
                    if (sb[k].inst == i) sb.delete(k);
            end else begin
                elig = req_v[i] & ~m_ack[i];
                win  = -1;
                for (int k = 0; k < 3; k++) begin
                    c = (i == 0) ? (m_last[i] + 1 + k) % 3 : k;
                    if (win < 0 && is_set(elig, c)) win = c;
                end
                m_ack[i]  = 3'b000;
                m_wren[i] = 1'b0;
                if (win >= 0) begin
                    w2         = 2'(win);
                    m_ack[i]   = 3'(32'd1 << win);
                    m_wren[i]  = we_v[i][w2];
                    m_addr[i]  = addr_v[i][w2];
                    m_data[i]  = wdata_v[i][w2];
                    m_last[i]  = win;
                    if (we_v[i][w2]) shadow[i][addr_v[i][w2]] = wdata_v[i][w2];
                    else sb.push_back('{cyc + 3, i, win, shadow[i][addr_v[i][w2]]});
                end
            end
        end
    end

    // Monitor: compares every strobe and bus each cycle, popping the scoreboard on due read returns.
    always @(negedge clock) begin
        logic [2:0] exp_rv;
        int         idx;
        if (cyc > 0) begin
            for (int i = 0; i < N_INST; i++) begin
                check(i, "ack", 32'(ack_o[i]), 32'(m_ack[i]));
                check(i, "ram_wren", 32'(ram_wren[i]), 32'(m_wren[i]));
                check(i, "ram_address", 32'(ram_address[i]), 32'(m_addr[i]));
                check(i, "ram_data", ram_data[i], m_data[i]);
                exp_rv = 3'b000;
                idx    = -1;
                for (int k = 0; k < sb.size(); k++)
                    if (idx < 0 && sb[k].inst == i) idx = k;
                if (idx >= 0 && sb[idx].due == cyc) begin
                    exp_rv     = 3'(32'd1 << sb[idx].id);
                    m_rdata[i] = sb[idx].data;
                    sb.delete(idx);
                end
                check(i, "rvalid", 32'(rvalid_o[i]), 32'(exp_rv));
                check(i, "rdata", rdata_o[i], m_rdata[i]);
            end
        end
    end

    // Driver knobs.
    logic [2:0]  en_mask  = 3'b000;
    int unsigned req_pct  = 0;
    int unsigned wr_pct   = 0;
    int unsigned addr_lim = 255;
    bit          chg_en   = 1'b0;
    logic [2:0]  seen [N_INST];

    task automatic new_fields(input int i, input int n);
        we_v[i][n]    = ($urandom_range(99) < wr_pct);
        addr_v[i][n]  = 8'($urandom_range(addr_lim));
        wdata_v[i][n] = $urandom;
    endtask

    // One cycle of requester behaviour: drop on ack, maybe raise a new request, maybe alter a pending one.
    task automatic drive_cycle();
        @(negedge clock);
        for (int i = 0; i < N_INST; i++) begin
            seen[i]  = ack_o[i];
            req_v[i] = req_v[i] & ~ack_o[i];
            for (int n = 0; n < 3; n++) begin
                if (!req_v[i][n] && is_set(en_mask, n) && $urandom_range(99) < req_pct) begin
                    req_v[i][n] = 1'b1;
                    new_fields(i, n);
                end else if (req_v[i][n] && chg_en && $urandom_range(3) == 0) begin
                    new_fields(i, n);
                end
            end
        end
    endtask

    task automatic issue(input int i, input int n, input bit w, input logic [7:0] a, input logic [31:0] d);
        req_v[i][n]   = 1'b1;
        we_v[i][n]    = w;
        addr_v[i][n]  = a;
        wdata_v[i][n] = d;
    endtask

    task automatic idle(input int c);
        en_mask = 3'b000;
        chg_en  = 1'b0;
        repeat (c) drive_cycle();
    endtask

    // Stop raising requests and wait, bounded, for every pending one to be acked.
    task automatic drain(input int budget);
        en_mask = 3'b000;
        chg_en  = 1'b0;
        for (int t = 0; t < budget && (req_v[0] != 3'b000 || req_v[1] != 3'b000); t++)
            drive_cycle();
        for (int i = 0; i < N_INST; i++) check(i, "grant_timeout", 32'(req_v[i]), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          wtr_ph [N_INST];
        logic [31:0] v;
        for (int i = 0; i < N_INST; i++) begin
            for (int k = 0; k < 256; k++) begin
                v            = $urandom;
                mem[i][k]    = v;
                shadow[i][k] = v;
            end
            mem[i][8'h10]    = 32'hDEADBEEF;
            shadow[i][8'h10] = 32'hDEADBEEF;
            req_v[i]    = 3'b000;
            we_v[i]     = 3'b000;
            rd_stage[i] = 32'h0;
            ram_q[i]    = 32'h0;
            for (int n = 0; n < 3; n++) begin
                addr_v[i][n]  = 8'h00;
                wdata_v[i][n] = 32'h0;
            end
        end

        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Single read of the preloaded word from requester 1.
        for (int i = 0; i < N_INST; i++) issue(i, 1, 1'b0, 8'h10, 32'h0);
        drain(20);
        idle(6);

        // All three requesters hold reads continuously.
        en_mask = 3'b111; req_pct = 100; wr_pct = 0; addr_lim = 255; chg_en = 1'b0;
        repeat (15) drive_cycle();
        drain(20);
        idle(6);

        // Requesters 0 and 2 held.
        en_mask = 3'b101; req_pct = 100; wr_pct = 0;
        repeat (12) drive_cycle();
        drain(20);
        idle(6);

        // Write then read of 0xFF from requester 0 at its next eligible slot.
        for (int i = 0; i < N_INST; i++) begin
            issue(i, 0, 1'b1, 8'hFF, 32'h12345678);
            wtr_ph[i] = 0;
        end
        for (int t = 0; t < 20 && !(wtr_ph[0] == 2 && wtr_ph[1] == 2); t++) begin
            drive_cycle();
            for (int i = 0; i < N_INST; i++) begin
                if (seen[i][0]) begin
                    if (wtr_ph[i] == 0) begin
                        issue(i, 0, 1'b0, 8'hFF, 32'h0);
                        wtr_ph[i] = 1;
                    end else if (wtr_ph[i] == 1) begin
                        wtr_ph[i] = 2;
                    end
                end
            end
        end
        for (int i = 0; i < N_INST; i++) check(i, "wtr_done", 32'(wtr_ph[i]), 32'd2);
        idle(6);

        // Three reads in flight, reset one edge after the last ack, requests present during reset.
        for (int i = 0; i < N_INST; i++)
            for (int n = 0; n < 3; n++) issue(i, n, 1'b0, 8'($urandom_range(255)), 32'h0);
        drain(20);
        drive_cycle();
        reset = 1'b1;
        for (int i = 0; i < N_INST; i++)
            for (int n = 0; n < 3; n++) issue(i, n, 1'b0, 8'($urandom_range(255)), 32'h0);
        drive_cycle();
        reset = 1'b0;
        drain(20);
        idle(6);

        // Single write followed by a long idle stretch.
        for (int i = 0; i < N_INST; i++) issue(i, 2, 1'b1, 8'h5A, 32'hCAFEF00D);
        drain(20);
        idle(10);

        // Random mixed traffic on a small address window, with pending-field churn and rare resets.
        en_mask = 3'b111; req_pct = 40; wr_pct = 40; addr_lim = 15; chg_en = 1'b1;
        repeat (2500) begin
            drive_cycle();
            reset = ($urandom_range(299) == 0);
        end
        reset = 1'b0;
        drain(40);
        idle(8);
        for (int i = 0; i < N_INST; i++) begin
            idx_count(i);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Every booked read return must have been delivered by the end.
    task automatic idx_count(input int i);
        int left;
        left = 0;
        for (int k = 0; k < sb.size(); k++)
            if (sb[k].inst == i) left++;
        check(i, "reads_outstanding", 32'(left), 32'h0);
    endtask
endmodule

// File: doc/dpram_port_arbiter.md
DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

Interface
REQ-001 SHALL have parameter: RR, default 1, 1 = round-robin arbitration, 0 = fixed priority (req0 > req1 > req2).
REQ-002 SHALL have port: clock  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports, for n = 0..2: reqn  input  1  access request, held until ackn.
REQ-005 SHALL have ports, for n = 0..2: wen  input  1  1 = write, 0 = read; valid with reqn.
REQ-006 SHALL have ports, for n = 0..2: addrn  input  8  word address.
REQ-007 SHALL have ports, for n = 0..2: wdatan  input  32  write data.
REQ-008 SHALL have ports, for n = 0..2: ackn  output  1  one-cycle grant pulse.
REQ-009 SHALL have ports, for n = 0..2: rvalidn  output  1  one-cycle pulse; rdata holds read result for requester n.
REQ-010 SHALL have port: rdata  output  32  registered read data, shared by all requesters.
REQ-011 SHALL have ports driving one port of a 256x32 dual-port RAM with 2-cycle registered read latency: ram_wren  output  1; ram_address  output  8; ram_data  output  32.
REQ-012 SHALL have port: ram_q  input  32  RAM read data.

Function
REQ-013 Arbitration SHALL be evaluated every clock edge over eligible requesters: reqn=1 and ackn currently 0.
- A requester acked in this cycle is masked.
- Max grant rate per requester: every other cycle.
- Max aggregate rate: one access per cycle.
REQ-014 On an edge with at least one eligible requester, the winner SHALL be registered:
- ram_address <= addrn; ram_data <= wdatan; ram_wren <= wen.
- ackn <= 1 for exactly one cycle, the same cycle the RAM access is presented.
REQ-015 On an edge with no eligible requester:
- ram_wren SHALL be 0 and all ack SHALL be 0.
- ram_address and ram_data SHALL hold their previous values.
REQ-016 RR=1: a 2-bit last-grant pointer SHALL update on every grant. The search SHALL start at (last+1) mod 3 and wrap 2->0. Pointer values other than 0..2 are unreachable.
REQ-017 RR=0: the lowest-index eligible requester SHALL win; the pointer is unused.
REQ-018 Read tracking: each read grant SHALL enter a 3-stage valid/ID shift pipeline (1 valid bit + 2-bit ID per stage). Writes SHALL enter as invalid.
REQ-019 Read latency: if ackn is high in cycle C, then rdata <= ram_q is captured at the end of cycle C+2, and rvalidn = 1 with rdata valid in cycle C+3.
REQ-020 Throughput: back-to-back reads from different requesters SHALL produce rvalid in consecutive cycles, in grant order, with no loss.
REQ-021 rdata SHALL hold its last captured value when no rvalid is asserted.
REQ-022 At most one rvalidn SHALL be high per cycle.
REQ-023 Write then read to the same address SHALL be issued in grant order. The RAM's read-during-write behaviour applies; the arbiter adds no forwarding.
REQ-024 A requester changing addr/we/wdata while reqn=1 and before ackn SHALL have the values sampled at the granting edge used.

Reset
REQ-025 While reset=1 at an edge, the following SHALL be cleared:
- ram_wren=0, ram_address=0, ram_data=0, rdata=0.
- all ackn=0, all rvalidn=0.
- all pipeline valid bits = 0.
- RR pointer = 2, so req0 wins first.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight reads (no rvalid after reset). Arbitration SHALL resume on the first edge with reset=0.
REQ-027 Requests asserted during reset SHALL NOT be granted until the first edge after reset deasserts.

Verification
REQ-028 Single read:
- Stimulus: preload RAM[0x10]=0xDEADBEEF; req1 read addr 0x10 at edge E0.
- Response: ack1 in cycle E0+1; rvalid1=1 and rdata=0xDEADBEEF in cycle E0+4; no other strobes.
REQ-029 Round-robin contention (RR=1):
- Stimulus: req0/1/2 all held continuously with reads.
- Response: grant order 0,1,2,0,1,2; each ack exactly one cycle; rvalids in the same order, 3 cycles after each ack.
REQ-030 Fixed priority (RR=0):
- Stimulus: req0 and req2 held.
- Response: grants alternate 0,2,0,2 (req0 masked in its ack cycle); req2 never starved.
REQ-031 Write then read:
- Stimulus: req0 write addr 0xFF data 0x12345678; req0 read addr 0xFF on its next eligible cycle.
- Response: no rvalid for the write; read returns 0x12345678 via rvalid0.
REQ-032 Reset mid-flight:
- Stimulus: issue 3 reads; assert reset for 1 cycle one edge after the last ack.
- Response: no rvalid in the following 5 cycles; all outputs 0; the next req0 is granted first.
REQ-033 Idle hold:
- Stimulus: a single write, then no requests for 10 cycles.
- Response: ram_wren=0 throughout the idle period; ram_address and ram_data unchanged.
